i2c_target: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 22 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_target.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared I2C target state encodings and bus-level constants
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_WAIT_BUS = 3'd7
  } i2c_state_e;

  // SDA levels as seen on the bus; NACK is also the released (open-drain high) level.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit counter load value: eight bits counted 7 down to 0, wrapping to 4'hF when a byte is complete.
  localparam logic [3:0] BIT_LAST = 4'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - bus line synchronizer with rise/fall strobes
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Resynchronize the line; reset to idle-high so leaving reset never shows an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - 7-bit address I2C target with byte strobe receive and request/sample transmit
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset_n(reset_n), .din(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset_n(reset_n), .din(sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high.
  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       out_q, out_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d, rx_first_d, tx_req_d, busy_d, stop_det_d;

  // Open-drain: only ever pull low or release.
  assign sda = out_q ? 1'bz : 1'b0;

  // State and datapath registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= BIT_LAST;
      shift_q    <= 8'h00;
      tx_shift_q <= 7'h00;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      out_q      <= NACK;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      out_q      <= out_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_first   <= rx_first_d;
      tx_req     <= tx_req_d;
      busy       <= busy_d;
      stop_det   <= stop_det_d;
    end
  end

  // Next-state logic: bus conditions first, then SCL-edge actions per state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    first_d    = first_q;
    out_d      = out_q;
    rx_data_d  = rx_data;
    rx_first_d = rx_first;
    busy_d     = busy;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    stop_det_d = 1'b0;

    if (stop_cond) begin
      stop_det_d = 1'b1;
      state_d    = ST_IDLE;
      out_d      = NACK;
      busy_d     = 1'b0;
    end else if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = BIT_LAST;
      out_d     = NACK;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall && bit_cnt_q[3]) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              rw_d    = shift_q[0];
              out_d   = ACK;
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_WAIT_BUS;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise && rw_q) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            bit_cnt_d = BIT_LAST;
            if (rw_q) begin
              tx_shift_d = tx_data[6:0];
              out_d      = tx_data[7];
              state_d    = ST_TX;
            end else begin
              out_d   = NACK;
              first_d = 1'b1;
              state_d = ST_RX;
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd0) begin
              rx_data_d  = {shift_q[6:0], sda_lvl};
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q[3]) begin
            out_d   = ACK;
            state_d = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            out_d     = NACK;
            bit_cnt_d = BIT_LAST;
            state_d   = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              out_d   = NACK;
              state_d = ST_TX_ACK;
            end else begin
              out_d      = tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q - 4'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK) begin
              tx_req_d = 1'b1;
            end else begin
              out_d   = NACK;
              busy_d  = 1'b0;
              state_d = ST_WAIT_BUS;
            end
          end else if (scl_fall) begin
            tx_shift_d = tx_data[6:0];
            out_d      = tx_data[7];
            bit_cnt_d  = BIT_LAST;
            state_d    = ST_TX;
          end
        end
        default: begin
          out_d = NACK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed and randomized bus transfers against a transaction-level model
module tb_i2c_target;

  localparam int         Q   = 100;
  localparam logic [6:0] OWN = 7'h42;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_req, busy, stop_det;
  logic [7:0] tx_data = 8'h00;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_target #(.TARGET_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  // Monitor: record strobes and serve read bytes from tx_mem in request order.
  logic [8:0] got_rx[$];
  logic [7:0] tx_mem[64];
  int n_txreq = 0, n_stop = 0, n_overlap = 0, n_busy_clks = 0, tx_idx = 0;
  always @(negedge clk) begin
    if (rx_valid) got_rx.push_back({rx_first, rx_data});
    if (tx_req) begin
      n_txreq++;
      tx_data = tx_mem[tx_idx % 64];
      tx_idx++;
    end
    if (stop_det) n_stop++;
    if (rx_valid && tx_req) n_overlap++;
    if (busy) n_busy_clks++;
  end

  int n_checks = 0, n_err = 0;
  logic [8:0] exp_rx[$];
  int rx_seen = 0, n_req_exp = 0, stop_exp = 0;
  logic [7:0] wbuf[8];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rx_count"}, got_rx.size(), exp_rx.size());
    for (int i = rx_seen; i < exp_rx.size() && i < got_rx.size(); i++)
      chk({tag, "_rx_byte"}, int'(got_rx[i]), int'(exp_rx[i]));
    rx_seen = exp_rx.size();
  endtask

  // Model: only the own address is ACKed; every data byte to it is ACKed and strobed once.
  task automatic do_write(input string tag, input logic [6:0] addr, input int n);
    logic ack;
    logic match;
    int   b0;
    match = (addr == OWN);
    b0 = n_busy_clks;
    bus_start();
    put_byte({addr, 1'b0}, ack);
    chk({tag, "_addr_ack"}, ack, match ? 0 : 1);
    if (match) chk({tag, "_busy_on"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], ack);
      chk({tag, "_data_ack"}, ack, match ? 0 : 1);
      if (match) exp_rx.push_back({(i == 0), wbuf[i]});
    end
    bus_stop();
    stop_exp++;
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_stop_cnt"}, n_stop, stop_exp);
    if (!match) chk({tag, "_busy_clks"}, n_busy_clks - b0, 0);
    check_rx(tag);
  endtask

  // Model: read bytes are tx_mem entries in request order; last byte NACKed.
  task automatic do_read(input string tag, input int n);
    logic       ack;
    logic [7:0] rd;
    bus_start();
    put_byte({OWN, 1'b1}, ack);
    chk({tag, "_addr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      get_byte(rd, (i == n - 1));
      chk({tag, "_byte"}, rd, tx_mem[n_req_exp % 64]);
      n_req_exp++;
    end
    chk({tag, "_busy_nack"}, busy, 0);
    chk({tag, "_sda_rel"}, sda_bus, 1);
    chk({tag, "_txreq_cnt"}, n_txreq, n_req_exp);
    bus_stop();
    stop_exp++;
    chk({tag, "_stop_cnt"}, n_stop, stop_exp);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [6:0] a;
    int         n;

    for (int i = 0; i < 64; i++) tx_mem[i] = 8'($urandom_range(0, 255));

    #50;
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_first", rx_first, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_sda", sda_bus, 1);
    reset_n = 1'b1;
    #200;

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write("wr2", OWN, 2);

    wbuf[0] = 8'h55;
    do_write("miss", 7'h43, 1);
    chk("miss_txreq", n_txreq, n_req_exp);

    tx_mem[n_req_exp % 64] = 8'h96;
    tx_mem[(n_req_exp + 1) % 64] = 8'h0F;
    do_read("rd2", 2);

    // Write then repeated START into a read, no STOP between.
    tx_mem[n_req_exp % 64] = 8'hC3;
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("rs_waddr_ack", ack, 0);
    put_byte(8'h11, ack);
    chk("rs_wdata_ack", ack, 0);
    exp_rx.push_back({1'b1, 8'h11});
    bus_start();
    chk("rs_no_stop", n_stop, stop_exp);
    put_byte({OWN, 1'b1}, ack);
    chk("rs_raddr_ack", ack, 0);
    get_byte(rd, 1'b1);
    chk("rs_byte", rd, 8'hC3);
    n_req_exp++;
    chk("rs_txreq_cnt", n_txreq, n_req_exp);
    bus_stop();
    stop_exp++;
    check_rx("rs");

    // STOP after four data bits discards the partial byte.
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("abort_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
    bus_stop();
    stop_exp++;
    chk("abort_stop_cnt", n_stop, stop_exp);
    chk("abort_busy", busy, 0);
    check_rx("abort");
    wbuf[0] = 8'h5A;
    do_write("after_abort", OWN, 1);

    // Randomized transfers.
    for (int it = 0; it < 4; it++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : OWN;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write("rand_wr", a, n);
      do_read("rand_rd", $urandom_range(1, 3));
    end

    // Asynchronous reset while the target pulls SDA low for a read bit.
    tx_mem[n_req_exp % 64] = 8'h00;
    bus_start();
    put_byte({OWN, 1'b1}, ack);
    chk("rst_addr_ack", ack, 0);
    n_req_exp++;
    m_sda = 1'b1; #Q; scl = 1'b1; #Q;
    chk("rst_pre_drive", sda_bus, 0);
    #3; reset_n = 1'b0; #1;
    chk("rst_mid_sda", sda_bus, 1);
    chk("rst_mid_rx_data", rx_data, 0);
    chk("rst_mid_rx_valid", rx_valid, 0);
    chk("rst_mid_rx_first", rx_first, 0);
    chk("rst_mid_tx_req", tx_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_stop_det", stop_det, 0);
    #6; reset_n = 1'b1;
    #(Q - 10); scl = 1'b0; #Q;
    wbuf[0] = 8'h77; wbuf[1] = 8'h88;
    do_write("post_rst", OWN, 2);

    chk("final_txreq", n_txreq, n_req_exp);
    chk("final_overlap", n_overlap, 0);
    chk("final_stop", n_stop, stop_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
